// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: round-robin arbiter and 4-beat line-refill sequencer for the single-ported data memory
module dmem_port_arbiter #(
  parameter int BURST_LEN = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        r0_req_i,
  input  logic        r0_wen_i,
  input  logic        r0_burst_i,
  input  logic [11:0] r0_addr_i,
  input  logic [3:0]  r0_be_i,
  input  logic [31:0] r0_wdata_i,
  output logic        r0_gnt_o,
  output logic        r0_rvalid_o,
  output logic        r0_done_o,
  input  logic        r1_req_i,
  input  logic        r1_wen_i,
  input  logic        r1_burst_i,
  input  logic [11:0] r1_addr_i,
  input  logic [3:0]  r1_be_i,
  input  logic [31:0] r1_wdata_i,
  output logic        r1_gnt_o,
  output logic        r1_rvalid_o,
  output logic        r1_done_o,
  output logic [31:0] rdata_o,
  output logic        mem_csn_o,
  output logic        mem_wen_o,
  output logic [11:0] mem_addr_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_dout_o,
  input  logic [31:0] mem_di_i
);
  typedef enum logic [1:0] {IDLE, XFER, LAST} state_e;
  state_e      state_q;
  logic        last_q;
  logic        owner_q;
  logic        wen_q;
  logic        burst_q;
  logic [1:0]  beat_q;
  logic [9:0]  line_q;
  logic [1:0]  gnt_q;
  logic [1:0]  rvalid_q;
  logic [1:0]  done_q;
  logic [31:0] rdata_q;
  logic        mem_csn_q;
  logic        mem_wen_q;
  logic [11:0] mem_addr_q;
  logic [3:0]  mem_be_q;
  logic [31:0] mem_dout_q;
  logic        pick1;
  logic        sel_wen;
  logic        sel_burst;
  logic [11:0] sel_addr;
  logic [3:0]  sel_be;
  logic [31:0] sel_wdata;
  logic [1:0]  win_vec;
  logic [1:0]  own_vec;
  // R1 wins when alone, or on a tie when R0 was the last one granted
  assign pick1     = r1_req_i & (~r0_req_i | ~last_q);
  assign sel_wen   = pick1 ? r1_wen_i : r0_wen_i;
  assign sel_burst = sel_wen & (pick1 ? r1_burst_i : r0_burst_i);
  assign sel_addr  = pick1 ? r1_addr_i : r0_addr_i;
  assign sel_be    = pick1 ? r1_be_i : r0_be_i;
  assign sel_wdata = pick1 ? r1_wdata_i : r0_wdata_i;
  assign win_vec   = pick1 ? 2'b10 : 2'b01;
  assign own_vec   = owner_q ? 2'b10 : 2'b01;
  // Transfer FSM with all requester and memory outputs registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;
      owner_q    <= 1'b0;
      wen_q      <= 1'b1;
      burst_q    <= 1'b0;
      beat_q     <= 2'd0;
      line_q     <= 10'd0;
      gnt_q      <= 2'b00;
      rvalid_q   <= 2'b00;
      done_q     <= 2'b00;
      rdata_q    <= 32'd0;
      mem_csn_q  <= 1'b1;
      mem_wen_q  <= 1'b1;
      mem_addr_q <= 12'd0;
      mem_be_q   <= 4'd0;
      mem_dout_q <= 32'd0;
    end else begin
      gnt_q    <= 2'b00;
      rvalid_q <= 2'b00;
      done_q   <= 2'b00;
      case (state_q)
        IDLE: if (r0_req_i | r1_req_i) begin
          state_q    <= XFER;
          owner_q    <= pick1;
          last_q     <= pick1;
          wen_q      <= sel_wen;
          burst_q    <= sel_burst;
          beat_q     <= 2'd0;
          line_q     <= sel_addr[11:2];
          gnt_q      <= win_vec;
          done_q     <= sel_wen ? 2'b00 : win_vec;
          mem_csn_q  <= 1'b0;
          mem_wen_q  <= sel_wen;
          mem_addr_q <= sel_burst ? {sel_addr[11:2], 2'b00} : sel_addr;
          mem_be_q   <= sel_wen ? 4'hF : sel_be;
          mem_dout_q <= sel_wdata;
        end
        XFER: begin
          if (wen_q) begin
            rdata_q  <= mem_di_i;
            rvalid_q <= own_vec;
          end
          if (!wen_q) begin
            state_q   <= IDLE;
            mem_csn_q <= 1'b1;
          end else if (burst_q && beat_q != 2'(BURST_LEN - 1)) begin
            beat_q     <= beat_q + 2'd1;
            mem_addr_q <= {line_q, beat_q + 2'd1};
          end else begin
            state_q   <= LAST;
            mem_csn_q <= 1'b1;
            done_q    <= own_vec;
          end
        end
        LAST: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign r0_gnt_o    = gnt_q[0];
  assign r1_gnt_o    = gnt_q[1];
  assign r0_rvalid_o = rvalid_q[0];
  assign r1_rvalid_o = rvalid_q[1];
  assign r0_done_o   = done_q[0];
  assign r1_done_o   = done_q[1];
  assign rdata_o     = rdata_q;
  assign mem_csn_o   = mem_csn_q;
  assign mem_wen_o   = mem_wen_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_be_o    = mem_be_q;
  assign mem_dout_o  = mem_dout_q;
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: randomized scoreboard bench with a transaction-level model of arbitration and memory contents
module tb_dmem_port_arbiter;
  logic        clk;
  logic        rst_n;
  logic        r0_req_i, r0_wen_i, r0_burst_i;
  logic [11:0] r0_addr_i;
  logic [3:0]  r0_be_i;
  logic [31:0] r0_wdata_i;
  logic        r0_gnt_o, r0_rvalid_o, r0_done_o;
  logic        r1_req_i, r1_wen_i, r1_burst_i;
  logic [11:0] r1_addr_i;
  logic [3:0]  r1_be_i;
  logic [31:0] r1_wdata_i;
  logic        r1_gnt_o, r1_rvalid_o, r1_done_o;
  logic [31:0] rdata_o;
  logic        mem_csn_o, mem_wen_o;
  logic [11:0] mem_addr_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_dout_o;
  logic [31:0] mem_di_i;

  dmem_port_arbiter #(.BURST_LEN(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .r0_req_i(r0_req_i), .r0_wen_i(r0_wen_i), .r0_burst_i(r0_burst_i), .r0_addr_i(r0_addr_i),
    .r0_be_i(r0_be_i), .r0_wdata_i(r0_wdata_i), .r0_gnt_o(r0_gnt_o), .r0_rvalid_o(r0_rvalid_o), .r0_done_o(r0_done_o),
    .r1_req_i(r1_req_i), .r1_wen_i(r1_wen_i), .r1_burst_i(r1_burst_i), .r1_addr_i(r1_addr_i),
    .r1_be_i(r1_be_i), .r1_wdata_i(r1_wdata_i), .r1_gnt_o(r1_gnt_o), .r1_rvalid_o(r1_rvalid_o), .r1_done_o(r1_done_o),
    .rdata_o(rdata_o), .mem_csn_o(mem_csn_o), .mem_wen_o(mem_wen_o), .mem_addr_o(mem_addr_o),
    .mem_be_o(mem_be_o), .mem_dout_o(mem_dout_o), .mem_di_i(mem_di_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        v;
    logic        wen;
    logic        burst;
    logic [11:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
  } req_t;

  typedef struct packed {
    logic             who;
    logic             rd;
    logic [2:0]       n;
    logic [3:0][11:0] a;
    logic [3:0][31:0] d;
    logic [3:0]       be;
    logic [31:0]      wd;
  } exp_t;

  logic [31:0] mem [4096];
  logic [31:0] ref_mem [4096];
  req_t        pend [2];
  exp_t        expq [$];
  int          last_w;
  int          checks;
  int          fails;

  assign mem_di_i = mem[mem_addr_o];

  always @(posedge clk)
    if (!mem_csn_o && !mem_wen_o)
      for (int b = 0; b < 4; b++)
        if (mem_be_o[b]) mem[mem_addr_o][8*b +: 8] = mem_dout_o[8*b +: 8];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
    end
  endtask

  task automatic finish_tb();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  endtask

  task automatic drive();
    r0_req_i = pend[0].v; r0_wen_i = pend[0].wen; r0_burst_i = pend[0].burst;
    r0_addr_i = pend[0].addr; r0_be_i = pend[0].be; r0_wdata_i = pend[0].wd;
    r1_req_i = pend[1].v; r1_wen_i = pend[1].wen; r1_burst_i = pend[1].burst;
    r1_addr_i = pend[1].addr; r1_be_i = pend[1].be; r1_wdata_i = pend[1].wd;
  endtask

  function automatic req_t rand_req();
    req_t r;
    r.v     = 1'b1;
    r.wen   = $urandom_range(0, 2) != 0;
    r.burst = 1'($urandom_range(0, 1));
    r.addr  = 12'($urandom_range(0, 31)) | (($urandom_range(0, 3) == 0) ? 12'hFC0 : 12'h000);
    r.be    = 4'($urandom);
    r.wd    = $urandom;
    return r;
  endfunction

  function automatic req_t mk(input logic wen, input logic burst, input logic [11:0] addr,
                              input logic [3:0] be, input logic [31:0] wd);
    req_t r;
    r.v = 1'b1; r.wen = wen; r.burst = burst; r.addr = addr; r.be = be; r.wd = wd;
    return r;
  endfunction

  // Model: winner by round-robin over pending requests, data from a serialized memory image
  task automatic predict(output exp_t e);
    int   w;
    req_t p;
    logic bst;
    w = (pend[0].v && pend[1].v) ? 1 - last_w : (pend[1].v ? 1 : 0);
    last_w = w;
    p = pend[w];
    e = '0;
    e.who = 1'(w);
    e.rd  = p.wen;
    bst   = p.wen && p.burst;
    e.n   = bst ? 3'd4 : 3'd1;
    e.be  = p.be;
    e.wd  = p.wd;
    for (int i = 0; i < int'(e.n); i++) begin
      e.a[i] = bst ? ((p.addr & 12'hFFC) + 12'(i)) : p.addr;
      e.d[i] = ref_mem[e.a[i]];
    end
    if (!p.wen)
      for (int b = 0; b < 4; b++)
        if (p.be[b]) ref_mem[p.addr][8*b +: 8] = p.wd[8*b +: 8];
  endtask

  task automatic arbitrate();
    exp_t e;
    int   cyc;
    drive();
    predict(e);
    expq.push_back(e);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!(r0_gnt_o || r1_gnt_o) && cyc < 40);
    if (!(r0_gnt_o || r1_gnt_o)) begin
      chk("gnt_timeout", 32'd0, 32'd1);
      finish_tb();
    end
    pend[e.who].v = 1'b0;
    drive();
  endtask

  task automatic drain();
    int cyc;
    cyc = 0;
    while ((expq.size() != 0 || mon_act) && cyc < 100) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    chk("drain", 32'(expq.size() != 0 || mon_act), 32'd0);
  endtask

  exp_t mon_cur;
  logic mon_act;
  int   mon_k;
  logic [1:0] mon_ov;
  logic mon_rv;
  int   mon_last;

  // Monitor: pops an expectation on each grant and checks every following cycle of that transfer
  always @(negedge clk) begin
    if (!rst_n) begin
      mon_act = 1'b0;
      expq.delete();
    end else begin
      if (!mon_act && (r0_gnt_o || r1_gnt_o)) begin
        if (expq.size() == 0) chk("spurious_gnt", 32'({r1_gnt_o, r0_gnt_o}), 32'd0);
        else begin
          mon_cur = expq.pop_front();
          mon_act = 1'b1;
          mon_k   = 0;
        end
      end
      if (mon_act) begin
        mon_ov   = mon_cur.who ? 2'b10 : 2'b01;
        mon_last = mon_cur.rd ? int'(mon_cur.n) : 0;
        chk("gnt", 32'({r1_gnt_o, r0_gnt_o}), 32'(mon_k == 0 ? mon_ov : 2'b00));
        chk("csn", 32'(mem_csn_o), 32'(mon_k >= int'(mon_cur.n)));
        if (mon_k < int'(mon_cur.n)) begin
          chk("mem_wen", 32'(mem_wen_o), 32'(mon_cur.rd));
          chk("mem_addr", 32'(mem_addr_o), 32'(mon_cur.a[mon_k]));
          chk("mem_be", 32'(mem_be_o), 32'(mon_cur.rd ? 4'hF : mon_cur.be));
          if (!mon_cur.rd) chk("mem_dout", mem_dout_o, mon_cur.wd);
        end
        mon_rv = mon_cur.rd && mon_k >= 1 && mon_k <= int'(mon_cur.n);
        chk("rvalid", 32'({r1_rvalid_o, r0_rvalid_o}), 32'(mon_rv ? mon_ov : 2'b00));
        if (mon_rv) chk("rdata", rdata_o, mon_cur.d[mon_k-1]);
        chk("done", 32'({r1_done_o, r0_done_o}), 32'(mon_k == mon_last ? mon_ov : 2'b00));
        if (mon_k == mon_last) mon_act = 1'b0;
        else mon_k++;
      end else begin
        chk("idle", 32'({mem_csn_o, r1_rvalid_o, r0_rvalid_o, r1_done_o, r0_done_o}), 32'h10);
      end
    end
  end

  initial begin
    checks = 0;
    fails = 0;
    last_w = 1;
    mon_act = 1'b0;
    mon_k = 0;
    for (int i = 0; i < 4096; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[12'h010] = 32'hDEAD_BEEF;
    ref_mem[12'h010] = 32'hDEAD_BEEF;
    pend[0] = '0;
    pend[1] = '0;
    drive();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_csn", 32'(mem_csn_o), 32'd1);
    chk("rst_wen", 32'(mem_wen_o), 32'd1);
    chk("rst_addr", 32'(mem_addr_o), 32'd0);
    chk("rst_be", 32'(mem_be_o), 32'd0);
    chk("rst_dout", mem_dout_o, 32'd0);
    chk("rst_rdata", rdata_o, 32'd0);
    chk("rst_flags", 32'({r1_gnt_o, r0_gnt_o, r1_rvalid_o, r0_rvalid_o, r1_done_o, r0_done_o}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    pend[0] = mk(1'b1, 1'b0, 12'h010, 4'h0, 32'h0);
    arbitrate();
    pend[1] = mk(1'b1, 1'b1, 12'h023, 4'h0, 32'h0);
    arbitrate();
    pend[0] = mk(1'b1, 1'b0, 12'h030, 4'h0, 32'h0);
    arbitrate();
    pend[1] = mk(1'b0, 1'b0, 12'h044, 4'b0011, 32'h1234_5678);
    arbitrate();
    pend[1] = mk(1'b0, 1'b1, 12'h045, 4'b1100, 32'hCAFE_F00D);
    arbitrate();
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 2; j++)
        if (!pend[j].v) pend[j] = mk(1'b1, 1'b0, 12'($urandom_range(0, 63)), 4'h0, 32'h0);
      arbitrate();
    end

    for (int i = 0; i < 200; i++) begin
      for (int j = 0; j < 2; j++)
        if (!pend[j].v && $urandom_range(0, 2) != 0) pend[j] = rand_req();
      if (!pend[0].v && !pend[1].v) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        pend[$urandom_range(0, 1)] = rand_req();
      end
      arbitrate();
    end
    pend[0].v = 1'b0;
    pend[1].v = 1'b0;
    drive();
    drain();

    pend[1] = mk(1'b1, 1'b1, 12'h100, 4'h0, 32'h0);
    arbitrate();
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_csn", 32'(mem_csn_o), 32'd1);
    chk("abort_flags", 32'({r1_gnt_o, r0_gnt_o, r1_rvalid_o, r0_rvalid_o, r1_done_o, r0_done_o}), 32'd0);
    last_w = 1;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    pend[0] = mk(1'b1, 1'b0, 12'h011, 4'h0, 32'h0);
    pend[1] = mk(1'b1, 1'b0, 12'h012, 4'h0, 32'h0);
    arbitrate();
    arbitrate();
    drain();
    finish_tb();
  end
endmodule
